// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
// Shared types and helpers for the PCI bus arbiter.
//   arb_state_e : arbiter FSM states with fixed encoding
//                 (GAP = all grants high, GRANT = owner granted on idle bus,
//                  BUSY = owner's transaction in flight)
//   idx_width() : width of a master index for a given master count
// ---------------------------------------------------------------------------
package pci_arb_pkg;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

    // Width needed to hold an index 0..n-1 (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter_if
// Arbitration signals shared between the central arbiter and the bus agents.
//   req   : per-master request, active-low (driven by the agents)
//   frame : bus FRAME, active-low (observed by the arbiter)
//   irdy  : bus IRDY, active-low (observed by the arbiter)
//   gnt   : per-master grant, active-low (driven by the arbiter)
// Modports:
//   master : the arbiter side, which controls the grants
//   slave  : the agent side, which requests and drives FRAME/IRDY
// ---------------------------------------------------------------------------
interface pci_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] req;
    logic                   frame;
    logic                   irdy;
    logic [NUM_MASTERS-1:0] gnt;

    modport master (
        input  req,
        input  frame,
        input  irdy,
        output gnt
    );

    modport slave (
        output req,
        output frame,
        output irdy,
        input  gnt
    );
endinterface

// File: rtl/pci_rr_picker.sv
// ---------------------------------------------------------------------------
// pci_rr_picker
// Combinational round-robin search. Starting one past the pointer, walks the
// request vector upward with wrap-around and returns the first requester.
// The pointer's own index is visited last, so the previous winner only wins
// again when nobody else is asking.
//   req    : request vector, active-high
//   ptr    : index of the last winner
//   winner : selected index (equals ptr when nothing is requested)
//   valid  : at least one request present
// ---------------------------------------------------------------------------
module pci_rr_picker
    import pci_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    always_comb begin
        // NOTE: both outputs get a default before the loop so every path
        // assigns them and no latch is inferred.
        winner = ptr;
        valid  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int idx;
            idx = int'(ptr) + k;
            // Explicit wrap keeps non-power-of-two master counts correct.
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!valid && req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pci_bus_arbiter
// Central PCI arbiter: round-robin grants, hidden arbitration during a
// running transaction, bus parking when nobody requests, and revocation of
// a grant the owner does not use within GNT_TIMEOUT idle-bus clocks.
// Observes FRAME/IRDY only; never drives shared bus lines.
// Ports:
//   clk         : bus clock, rising edge
//   rst         : synchronous reset, active-high
//   bus         : pci_bus_arbiter_if.master (req/frame/irdy in, gnt out)
//   cur_master  : index of the current or most recent grant owner
//   bus_idle    : registered FRAME & IRDY of the previous cycle
//   timeout_evt : one-cycle pulse when a grant is revoked for non-use
// ---------------------------------------------------------------------------
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter  int NUM_MASTERS  = 4,
    parameter  int GNT_TIMEOUT  = 16,
    parameter  int PARK_DEFAULT = 0,
    localparam int IDX_W        = idx_width(NUM_MASTERS),
    localparam int TMR_W        = $clog2(GNT_TIMEOUT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    pci_bus_arbiter_if.master bus,
    output logic [IDX_W-1:0]  cur_master,
    output logic              bus_idle,
    output logic              timeout_evt
);

    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_DEFAULT);

    arb_state_e             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   parked;
    logic [TMR_W-1:0]       timer;
    logic                   idle_q;
    logic [NUM_MASTERS-1:0] gnt_q;

    logic [NUM_MASTERS-1:0] req_act;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic [NUM_MASTERS-1:0] pick_mask;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   any_req;
    logic                   other_req;
    logic                   owner_req;
    logic                   start_det;
    logic                   bus_idle_now;
    logic                   timer_done;

    assign req_act      = ~bus.req;
    assign owner_mask   = NUM_MASTERS'(1) << owner;
    assign pick_mask    = NUM_MASTERS'(1) << pick_idx;
    assign any_req      = |req_act;
    assign other_req    = |(req_act & ~owner_mask);
    assign owner_req    = req_act[owner];
    assign bus_idle_now = bus.frame & bus.irdy;
    // A transaction starts when FRAME falls on a bus that was idle last cycle.
    assign start_det    = ~bus.frame & idle_q;
    assign timer_done   = (timer == TMR_W'(GNT_TIMEOUT - 1));

    pci_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req    (req_act),
        .ptr    (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_GAP;
            owner       <= PARK_IDX;
            rr_ptr      <= PARK_IDX;
            parked      <= 1'b1;
            timer       <= '0;
            idle_q      <= 1'b1;
            gnt_q       <= '1;
            timeout_evt <= 1'b0;
        end else begin
            idle_q      <= bus_idle_now;
            timeout_evt <= 1'b0;
            case (state)
                ST_GAP: begin
                    state <= ST_GRANT;
                    timer <= '0;
                    if (pick_valid) begin
                        owner  <= pick_idx;
                        rr_ptr <= pick_idx;
                        parked <= 1'b0;
                        gnt_q  <= ~pick_mask;
                    end else begin
                        // Nobody asking: park the bus on the last owner.
                        parked <= 1'b1;
                        gnt_q  <= ~owner_mask;
                    end
                end

                ST_GRANT: begin
                    if (start_det) begin
                        state <= ST_BUSY;
                    end else if (parked && any_req) begin
                        state <= ST_GAP;
                        gnt_q <= '1;
                    end else if (!parked && !owner_req) begin
                        state <= ST_GAP;
                        gnt_q <= '1;
                    end else if (!parked && idle_q) begin
                        // Unused grant on an idle bus. rr_ptr already holds
                        // the owner, so it becomes lowest priority next pick.
                        if (timer_done) begin
                            state       <= ST_GAP;
                            gnt_q       <= '1;
                            timeout_evt <= 1'b1;
                        end else if (timer != '1) begin
                            timer <= timer + 1'b1;
                        end
                    end
                    // Otherwise the previous master is still finishing:
                    // the timer holds its value.
                end

                ST_BUSY: begin
                    if (other_req) begin
                        // Hidden arbitration: the owner finishes its
                        // transaction without a grant.
                        state <= ST_GAP;
                        gnt_q <= '1;
                    end else if (bus_idle_now) begin
                        state <= ST_GRANT;
                        timer <= '0;
                    end
                end

                default: begin
                    state <= ST_GAP;
                    gnt_q <= '1;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt_q;
    assign cur_master = owner;
    assign bus_idle   = idle_q;

endmodule
